// File: rtl/div4b_pkg.sv
// div4b_pkg: shared widths, step count, state encoding and divide-by-zero quotient for div4b_seq
package div4b_pkg;
  localparam int WIDTH = 4;
  localparam int STEPS = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [WIDTH-1:0] DIV0_Q = 4'hF;
endpackage

// File: rtl/div4b_seq_sub5b.sv
// sub5b: combinational 5-bit ripple-borrow subtractor (Diff = A - B - Bin) built from full-subtractor cells
//   A, B  : 5-bit operands
//   Bin   : borrow into bit 0
//   Diff  : 5-bit difference
//   Bout  : borrow out of bit 4 (set when A < B + Bin)
module sub5b
  import div4b_pkg::*;
(
  input  logic [WIDTH:0] A,
  input  logic [WIDTH:0] B,
  input  logic           Bin,
  output logic [WIDTH:0] Diff,
  output logic           Bout
);
  logic [WIDTH+1:0] bw;
  assign bw[0] = Bin;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
    assign Diff[i]  = A[i] ^ B[i] ^ bw[i];
    assign bw[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
  end
  assign Bout = bw[WIDTH+1];
endmodule

// File: rtl/div4b_seq.sv
// div4b_seq: sequential 4-bit unsigned restoring divider, one quotient bit per clock
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, accepted only while busy=0
//   A, B         : dividend, divisor (captured on accepted start)
//   busy         : division in progress
//   done         : one-cycle pulse, Q/R valid from this cycle
//   Q, R         : quotient, remainder (held until next result)
//   div_zero     : divisor-was-zero flag, present only with DIV4B_ZERO_DETECT_EN
//   DIV4B_ZERO_DETECT_EN: B==0 finishes in one cycle with Q=F, R=A, div_zero=1
module div4b_seq
  import div4b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
`ifdef DIV4B_ZERO_DETECT_EN
  ,output logic            div_zero
`endif
);
  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
`ifdef DIV4B_ZERO_DETECT_EN
  logic             dz_q, dz_d;
`endif
  logic [WIDTH:0]   shin, diff;
  logic             bout, restore;
  assign shin = {rem_q, dvd_q[WIDTH-1]};
  sub5b u_sub (
    .A    (shin),
    .B    ({1'b0, div_q}),
    .Bin  (1'b0),
    .Diff (diff),
    .Bout (bout)
  );
  // diff[WIDTH] is zero whenever there is no borrow; folding it in keeps the full result in the decision
  assign restore = bout | diff[WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV4B_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    if (state_q == RUN) begin
      rem_d = restore ? shin[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~restore};
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = DONE;
        q_d     = quo_d;
        r_d     = rem_d;
      end
    end else if (start) begin
      state_d = RUN;
      dvd_d   = A;
      div_d   = B;
      rem_d   = '0;
      quo_d   = '0;
      cnt_d   = 2'(STEPS - 1);
`ifdef DIV4B_ZERO_DETECT_EN
      dz_d    = (B == '0);
      if (B == '0) begin
        state_d = DONE;
        q_d     = DIV0_Q;
        r_d     = A;
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIV4B_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIV4B_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
`ifdef DIV4B_ZERO_DETECT_EN
  assign div_zero = dz_q;
`endif
endmodule
